multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
Multi-cycle successor to the single-cycle opcode decoder for the RV64I datapath. It sequences each instruction through fetch, decode, execute, memory and writeback states. Memory accesses use a ready handshake. It also flags illegal opcodes and counts retired instructions. It sits between the instruction register (IR) and the shared-memory multicycle datapath, and drives all mux selects and write enables.

Parameters:
OPCODE_W, 7, width of the opcode field taken from IR[6:0]
ALUOP_W, 2, width of the ALU-op code sent to the ALU control block
CNT_W, 32, width of the retired-instruction counter

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
opcode  input  OPCODE_W  IR opcode; IR is written only in FETCH, so opcode is stable for the rest of the instruction
mem_ready  input  1  memory has completed the current read or write this cycle
zero  input  1  ALU zero flag, used for beq
pc_en  output  1  PC write enable
ir_write  output  1  IR and OldPC load enable
iord  output  1  memory address select: 0 = PC, 1 = ALUOut
mem_read  output  1  memory read request
mem_write  output  1  memory write request
reg_write  output  1  register-file write enable
wb_sel  output  2  writeback select: 00 = ALUOut, 01 = MDR, 10 = PC (already PC+4)
alu_src_a  output  2  ALU A select: 00 = PC, 01 = rs1, 10 = OldPC
alu_src_b  output  2  ALU B select: 00 = rs2, 01 = constant 4, 10 = imm, 11 = imm (branch/jal offset)
alu_op  output  ALUOP_W  00 = add, 01 = sub/compare, 10 = R-type funct, 11 = I-type funct
pc_source  output  1  PC input select: 0 = ALU result, 1 = ALUOut
illegal_instr  output  1  one-cycle pulse when the opcode is undecodable
retired_cnt  output  CNT_W  count of completed instructions

Behaviour:
- Moore FSM with a registered state. Outputs are decoded combinationally from the state, plus mem_ready/zero where noted.
- Any output not listed for a state is 0.
- Reset:
  - state <= FETCH, retired_cnt <= 0.
  - While reset = 1, every output is forced to 0, including mem_read and mem_write. A reset mid-transaction therefore aborts the access immediately.
  - FETCH is entered on the first cycle after reset deasserts.
- FETCH:
  - Outputs: mem_read = 1, iord = 0, alu_src_a = 00, alu_src_b = 01, alu_op = 00.
  - ir_write = pc_en = mem_ready, with pc_source = 0.
  - Stay in FETCH until mem_ready = 1, then go to DECODE.
- DECODE:
  - Outputs: alu_src_a = 10, alu_src_b = 11, alu_op = 00 (branch/jump target into ALUOut).
  - Next state by opcode:
    - 0110011 -> EXEC_R
    - 0010011 -> EXEC_I
    - 0000011 or 0100011 -> MEM_ADDR
    - 1100011 -> BRANCH
    - 1101111 -> JAL
    - any other opcode -> ILLEGAL
- EXEC_R: alu_src_a = 01, alu_src_b = 00, alu_op = 10; next ALU_WB.
- EXEC_I: alu_src_a = 01, alu_src_b = 10, alu_op = 11; next ALU_WB.
- ALU_WB: reg_write = 1, wb_sel = 00; next FETCH; retire.
- MEM_ADDR: alu_src_a = 01, alu_src_b = 10, alu_op = 00; next MEM_RD if opcode = 0000011, else MEM_WR.
- MEM_RD: iord = 1, mem_read = 1; hold until mem_ready = 1, then MEM_WB.
- MEM_WB: reg_write = 1, wb_sel = 01; next FETCH; retire.
- MEM_WR: iord = 1, mem_write = 1; hold until mem_ready = 1, then FETCH; retire on the exit cycle.
- BRANCH:
  - Outputs: alu_src_a = 01, alu_src_b = 00, alu_op = 01, pc_source = 1, pc_en = zero.
  - Next FETCH; retire whether or not the branch is taken.
- JAL: pc_en = 1, pc_source = 1, reg_write = 1, wb_sel = 10; next FETCH; retire.
- ILLEGAL: illegal_instr = 1 for exactly one cycle; next FETCH; no retire.
- Retire:
  - retired_cnt increments by 1 on the clock edge leaving a retiring state.
  - The count wraps modulo 2^CNT_W with no saturation and no flag.
- Latencies, counting cycles from FETCH entry with zero memory wait: R/I = 4, ld = 5, sd = 4, beq = 3, jal = 3, illegal = 3. Each mem_ready-low cycle in FETCH, MEM_RD or MEM_WR adds one cycle.
- mem_read and mem_write are never asserted together; the bench asserts this every cycle.
- mem_ready seen outside FETCH, MEM_RD or MEM_WR is ignored.

Test Plan:
- Reset and idle: hold reset 3 cycles with mem_ready = 1 -> all outputs 0, retired_cnt = 0. First cycle after release: FETCH with mem_read = 1, alu_src_b = 01.
- R-type: opcode 0110011, mem_ready always 1 -> states FETCH, DECODE, EXEC_R, ALU_WB. reg_write = 1 with wb_sel = 00 on cycle 4; retired_cnt 0 -> 1.
- ld with wait states: opcode 0000011, mem_ready low for 2 cycles in FETCH and 3 cycles in MEM_RD:
  - ir_write pulses once, on the ready cycle of FETCH.
  - Total 10 cycles; reg_write = 1 with wb_sel = 01 in the last cycle.
- beq taken vs. not taken: opcode 1100011 with zero = 1 -> pc_en = 1 and pc_source = 1 in BRANCH. With zero = 0 -> pc_en = 0. retired_cnt increments in both cases.
- Illegal and jal:
  - opcode 1111111 -> illegal_instr = 1 for exactly one cycle, return to FETCH, retired_cnt unchanged.
  - opcode 1101111 -> pc_en = 1, reg_write = 1, wb_sel = 10.
- Reset mid-sd and counter wrap:
  - Assert reset while in MEM_WR with mem_ready = 0 -> mem_write = 0 in the same cycle, FETCH after release.
  - With CNT_W = 4, 16 retires -> retired_cnt returns to 0.

Source files
------------

// File: rtl/multicycle_control_if.sv
// multicycle_control_if: opcode/handshake inputs and control outputs between the controller and the datapath
interface multicycle_control_if #(
   parameter int OPCODE_W = 7,
   parameter int ALUOP_W  = 2,
   parameter int CNT_W    = 32
);
   logic [OPCODE_W-1:0] opcode;
   logic                mem_ready;
   logic                zero;
   logic                pc_en;
   logic                ir_write;
   logic                iord;
   logic                mem_read;
   logic                mem_write;
   logic                reg_write;
   logic [1:0]          wb_sel;
   logic [1:0]          alu_src_a;
   logic [1:0]          alu_src_b;
   logic [ALUOP_W-1:0]  alu_op;
   logic                pc_source;
   logic                illegal_instr;
   logic [CNT_W-1:0]    retired_cnt;
   modport master (
      output opcode, mem_ready, zero,
      input  pc_en, ir_write, iord, mem_read, mem_write, reg_write, wb_sel,
             alu_src_a, alu_src_b, alu_op, pc_source, illegal_instr, retired_cnt
   );
   modport slave (
      input  opcode, mem_ready, zero,
      output pc_en, ir_write, iord, mem_read, mem_write, reg_write, wb_sel,
             alu_src_a, alu_src_b, alu_op, pc_source, illegal_instr, retired_cnt
   );
endinterface

// File: rtl/multicycle_control.sv
// multicycle_control: Moore FSM sequencing RV64I instructions through fetch/decode/execute/memory/writeback
module multicycle_control #(
   parameter int OPCODE_W = 7,
   parameter int ALUOP_W  = 2,
   parameter int CNT_W    = 32
) (
   input logic                 clk,
   input logic                 reset,
   multicycle_control_if.slave bus
);
   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_ALU_WB, S_MEM_ADDR,
      S_MEM_RD, S_MEM_WB, S_MEM_WR, S_BRANCH, S_JAL, S_ILLEGAL
   } state_t;
   localparam logic [OPCODE_W-1:0] OP_R   = OPCODE_W'(7'b0110011);
   localparam logic [OPCODE_W-1:0] OP_I   = OPCODE_W'(7'b0010011);
   localparam logic [OPCODE_W-1:0] OP_LD  = OPCODE_W'(7'b0000011);
   localparam logic [OPCODE_W-1:0] OP_SD  = OPCODE_W'(7'b0100011);
   localparam logic [OPCODE_W-1:0] OP_BR  = OPCODE_W'(7'b1100011);
   localparam logic [OPCODE_W-1:0] OP_JAL = OPCODE_W'(7'b1101111);
   state_t           r_state, w_next, w_dec;
   logic [CNT_W-1:0] r_cnt;
   logic             w_retire;
   assign w_dec = bus.opcode == OP_R                          ? S_EXEC_R   :
                  bus.opcode == OP_I                          ? S_EXEC_I   :
                  (bus.opcode == OP_LD || bus.opcode == OP_SD) ? S_MEM_ADDR :
                  bus.opcode == OP_BR                         ? S_BRANCH   :
                  bus.opcode == OP_JAL                        ? S_JAL      : S_ILLEGAL;
   // a store retires only on the cycle its write completes
   assign w_retire = r_state == S_ALU_WB || r_state == S_MEM_WB || r_state == S_BRANCH ||
                     r_state == S_JAL || (r_state == S_MEM_WR && bus.mem_ready);
   assign bus.retired_cnt = r_cnt;
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_FETCH;
         r_cnt   <= '0;
      end else begin
         r_state <= w_next;
         if (w_retire) r_cnt <= r_cnt + CNT_W'(1);
      end
   end
   // outputs are gated by reset so an in-flight memory access drops immediately
   always_comb begin
      w_next            = r_state;
      bus.pc_en         = 1'b0;
      bus.ir_write      = 1'b0;
      bus.iord          = 1'b0;
      bus.mem_read      = 1'b0;
      bus.mem_write     = 1'b0;
      bus.reg_write     = 1'b0;
      bus.wb_sel        = 2'b00;
      bus.alu_src_a     = 2'b00;
      bus.alu_src_b     = 2'b00;
      bus.alu_op        = '0;
      bus.pc_source     = 1'b0;
      bus.illegal_instr = 1'b0;
      if (!reset)
         case (r_state)
            S_FETCH: begin
               bus.mem_read  = 1'b1;
               bus.alu_src_b = 2'b01;
               bus.ir_write  = bus.mem_ready;
               bus.pc_en     = bus.mem_ready;
               w_next        = bus.mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
               bus.alu_src_a = 2'b10;
               bus.alu_src_b = 2'b11;
               w_next        = w_dec;
            end
            S_EXEC_R: begin
               bus.alu_src_a = 2'b01;
               bus.alu_op    = ALUOP_W'(2'b10);
               w_next        = S_ALU_WB;
            end
            S_EXEC_I: begin
               bus.alu_src_a = 2'b01;
               bus.alu_src_b = 2'b10;
               bus.alu_op    = ALUOP_W'(2'b11);
               w_next        = S_ALU_WB;
            end
            S_ALU_WB: begin
               bus.reg_write = 1'b1;
               w_next        = S_FETCH;
            end
            S_MEM_ADDR: begin
               bus.alu_src_a = 2'b01;
               bus.alu_src_b = 2'b10;
               w_next        = bus.opcode == OP_LD ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
               bus.iord     = 1'b1;
               bus.mem_read = 1'b1;
               w_next       = bus.mem_ready ? S_MEM_WB : S_MEM_RD;
            end
            S_MEM_WB: begin
               bus.reg_write = 1'b1;
               bus.wb_sel    = 2'b01;
               w_next        = S_FETCH;
            end
            S_MEM_WR: begin
               bus.iord      = 1'b1;
               bus.mem_write = 1'b1;
               w_next        = bus.mem_ready ? S_FETCH : S_MEM_WR;
            end
            S_BRANCH: begin
               bus.alu_src_a = 2'b01;
               bus.alu_op    = ALUOP_W'(2'b01);
               bus.pc_source = 1'b1;
               bus.pc_en     = bus.zero;
               w_next        = S_FETCH;
            end
            S_JAL: begin
               bus.pc_en     = 1'b1;
               bus.pc_source = 1'b1;
               bus.reg_write = 1'b1;
               bus.wb_sel    = 2'b10;
               w_next        = S_FETCH;
            end
            S_ILLEGAL: begin
               bus.illegal_instr = 1'b1;
               w_next            = S_FETCH;
            end
            default: w_next = S_FETCH;
         endcase
   end
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: table-driven instruction vectors with a scoreboard, plus reset and wrap sequences
module tb_multicycle_control;
   localparam int CW = 4;
   logic clk = 1'b0;
   logic reset;
   int   total = 0;
   int   bad = 0;
   always #5 clk = ~clk;
   multicycle_control_if #(.OPCODE_W(7), .ALUOP_W(2), .CNT_W(CW)) bus ();
   multicycle_control #(.OPCODE_W(7), .ALUOP_W(2), .CNT_W(CW)) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );
   typedef struct {
      logic [6:0] op;
      logic       z;
      int         fw, mw;
      int         cyc, n_ir, n_rw;
      logic [1:0] wb;
      int         n_pc, n_psrc, n_ill, n_mw;
      logic [5:0] s2, s3;
      int         ret;
   } vec_t;
   vec_t tbl[12];
   vec_t sb[$];
   logic [19:0] all_outs;
   assign all_outs = {bus.pc_en, bus.ir_write, bus.iord, bus.mem_read, bus.mem_write, bus.reg_write,
                      bus.wb_sel, bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.pc_source,
                      bus.illegal_instr, bus.retired_cnt};
   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask
   // drives one instruction from its first FETCH cycle until the next FETCH begins
   task automatic run(input vec_t v, output vec_t o);
      int fwc = 0, mwc = 0, k = 0;
      bit prev_fetch = 0, done = 0, is_fetch;
      logic [CW-1:0] start = bus.retired_cnt;
      o = v;
      o.cyc = 0; o.n_ir = 0; o.n_rw = 0; o.wb = 2'b00; o.n_pc = 0; o.n_psrc = 0;
      o.n_ill = 0; o.n_mw = 0; o.s2 = '0; o.s3 = '0; o.ret = 0;
      bus.opcode = v.op;
      bus.zero = v.z;
      while (!done && o.cyc < 60) begin
         is_fetch = bus.mem_read && !bus.iord;
         if (o.cyc > 0 && is_fetch && !prev_fetch) done = 1;
         else begin
            if (is_fetch) begin
               bus.mem_ready = fwc >= v.fw;
               fwc++;
            end else if (bus.mem_read || bus.mem_write) begin
               bus.mem_ready = mwc >= v.mw;
               mwc++;
            end else bus.mem_ready = 1'($urandom_range(0, 1));
            #1;
            o.cyc++;
            if (o.cyc == 1) chk("fetch_sel", int'({bus.alu_src_a, bus.alu_src_b, bus.alu_op}), 6'b000100);
            if (!is_fetch) begin
               k++;
               if (k == 1) o.s2 = {bus.alu_src_a, bus.alu_src_b, bus.alu_op};
               if (k == 2) o.s3 = {bus.alu_src_a, bus.alu_src_b, bus.alu_op};
            end
            if (bus.mem_read && bus.mem_write) chk("rd_wr_excl", 1, 0);
            o.n_ir += int'(bus.ir_write);
            o.n_pc += int'(bus.pc_en);
            o.n_psrc += int'(bus.pc_source);
            o.n_ill += int'(bus.illegal_instr);
            o.n_mw += int'(bus.mem_write);
            if (bus.reg_write) begin
               o.n_rw++;
               o.wb = bus.wb_sel;
            end
            prev_fetch = is_fetch;
            @(negedge clk);
         end
      end
      if (!done) chk("timeout", 0, 1);
      o.ret = int'(CW'(bus.retired_cnt - start));
   endtask
   initial begin
      vec_t e, o;
      logic found;
      tbl[0]  = '{7'b0110011, 1'b0, 0, 0, 4, 1, 1, 2'b00, 1, 0, 0, 0, 6'b101100, 6'b010010, 1};
      tbl[1]  = '{7'b0010011, 1'b0, 0, 0, 4, 1, 1, 2'b00, 1, 0, 0, 0, 6'b101100, 6'b011011, 1};
      tbl[2]  = '{7'b0000011, 1'b0, 2, 3, 10, 1, 1, 2'b01, 1, 0, 0, 0, 6'b101100, 6'b011000, 1};
      tbl[3]  = '{7'b0100011, 1'b0, 0, 0, 4, 1, 0, 2'b00, 1, 0, 0, 1, 6'b101100, 6'b011000, 1};
      tbl[4]  = '{7'b0100011, 1'b0, 1, 2, 7, 1, 0, 2'b00, 1, 0, 0, 3, 6'b101100, 6'b011000, 1};
      tbl[5]  = '{7'b1100011, 1'b1, 0, 0, 3, 1, 0, 2'b00, 2, 1, 0, 0, 6'b101100, 6'b010001, 1};
      tbl[6]  = '{7'b1100011, 1'b0, 0, 0, 3, 1, 0, 2'b00, 1, 1, 0, 0, 6'b101100, 6'b010001, 1};
      tbl[7]  = '{7'b1101111, 1'b0, 0, 0, 3, 1, 1, 2'b10, 2, 1, 0, 0, 6'b101100, 6'b000000, 1};
      tbl[8]  = '{7'b1111111, 1'b0, 0, 0, 3, 1, 0, 2'b00, 1, 0, 1, 0, 6'b101100, 6'b000000, 0};
      tbl[9]  = '{7'b0000000, 1'b1, 0, 0, 3, 1, 0, 2'b00, 1, 0, 1, 0, 6'b101100, 6'b000000, 0};
      tbl[10] = '{7'b0110011, 1'b0, 3, 0, 7, 1, 1, 2'b00, 1, 0, 0, 0, 6'b101100, 6'b010010, 1};
      tbl[11] = '{7'b0000011, 1'b0, 0, 0, 5, 1, 1, 2'b01, 1, 0, 0, 0, 6'b101100, 6'b011000, 1};
      reset = 1'b1;
      bus.opcode = 7'b0100011;
      bus.mem_ready = 1'b1;
      bus.zero = 1'b0;
      repeat (3) begin
         @(negedge clk);
         #1 chk("reset_outs", int'(all_outs), 0);
      end
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("post_rst_mem_read", int'(bus.mem_read), 1);
      chk("post_rst_src_b", int'(bus.alu_src_b), 2'b01);
      chk("post_rst_cnt", int'(bus.retired_cnt), 0);
      for (int i = 0; i < 12; i++) begin
         sb.push_back(tbl[i]);
         run(tbl[i], o);
         e = sb.pop_front();
         chk($sformatf("v%0d_cycles", i), o.cyc, e.cyc);
         chk($sformatf("v%0d_ir_write", i), o.n_ir, e.n_ir);
         chk($sformatf("v%0d_reg_write", i), o.n_rw, e.n_rw);
         if (e.n_rw > 0) chk($sformatf("v%0d_wb_sel", i), int'(o.wb), int'(e.wb));
         chk($sformatf("v%0d_pc_en", i), o.n_pc, e.n_pc);
         chk($sformatf("v%0d_pc_source", i), o.n_psrc, e.n_psrc);
         chk($sformatf("v%0d_illegal", i), o.n_ill, e.n_ill);
         chk($sformatf("v%0d_mem_write", i), o.n_mw, e.n_mw);
         chk($sformatf("v%0d_decode_sel", i), int'(o.s2), int'(e.s2));
         chk($sformatf("v%0d_exec_sel", i), int'(o.s3), int'(e.s3));
         chk($sformatf("v%0d_retire", i), o.ret, e.ret);
         if (i == 0) chk("first_retire_cnt", int'(bus.retired_cnt), 1);
      end
      // reset while a store is stalled in MEM_WR
      bus.opcode = 7'b0100011;
      bus.mem_ready = 1'b1;
      @(negedge clk);
      bus.mem_ready = 1'b0;
      found = 1'b0;
      for (int c = 0; c < 8 && !found; c++) begin
         @(negedge clk);
         #1 found = bus.mem_write;
      end
      chk("sd_reached_mem_wr", int'(found), 1);
      reset = 1'b1;
      #1;
      chk("rst_mid_sd_mem_write", int'(bus.mem_write), 0);
      chk("rst_mid_sd_outs", int'(all_outs & 20'hFFFF0), 0);
      @(negedge clk);
      reset = 1'b0;
      bus.mem_ready = 1'b1;
      #1;
      chk("after_abort_fetch", int'({bus.mem_read, bus.iord, bus.alu_src_b}), 4'b1001);
      chk("after_abort_cnt", int'(bus.retired_cnt), 0);
      for (int n = 1; n <= 16; n++) begin
         run(tbl[n % 2], o);
         if (n == 15) chk("cnt_before_wrap", int'(bus.retired_cnt), 15);
      end
      chk("cnt_wrapped", int'(bus.retired_cnt), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
